// File: rtl/inst_fetch_unit_if.sv
// Instruction memory bus between the fetch unit and instruction memory.
// Ports (signals):
//   req    - one-cycle request pulse (fetch -> memory)
//   addr   - fetch address, valid while req=1 (fetch -> memory)
//   rvalid - response strobe, rdata valid this cycle (memory -> fetch)
//   rdata  - fetched instruction word (memory -> fetch)
interface inst_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/inst_fetch_unit.sv
// Multi-cycle instruction fetch stage feeding the control unit.
// Holds the PC, issues one outstanding request at a time, captures the
// returned word and computes the next PC when execute acknowledges it.
//
// Ports:
//   clk, rst_b          - clock, synchronous active-high reset
//   imem (master)       - instruction memory request/response bus
//   inst_valid          - instruction held and presented to decode
//   inst, inst_pc       - held instruction word and its address
//   opcode, func        - inst[31:26], inst[5:0]
//   inst_ack            - execute done; next-PC inputs valid this cycle
//   Jump/JumpReg/Branch/Halted - control unit outputs
//   branch_cond         - ALU zero flag
//   reg_target          - rs value for JR
//   halted              - fetch stopped until reset
//
// state  | meaning
// S_REQ  | request phase; first cycle after reset arms req, then req=1 for one cycle
// S_WAIT | waiting for imem rvalid, no timeout
// S_HOLD | instruction presented to decode until inst_ack
// S_HALT | fetch stopped until reset
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                      clk,
  input  logic                      rst_b,
  inst_fetch_unit_if.master         imem,
  output logic                      inst_valid,
  output logic [31:0]               inst,
  output logic [31:0]               inst_pc,
  output logic [5:0]                opcode,
  output logic [5:0]                func,
  input  logic                      inst_ack,
  input  logic                      Jump,
  input  logic                      JumpReg,
  input  logic                      Branch,
  input  logic                      Halted,
  input  logic                      branch_cond,
  input  logic [31:0]               reg_target,
  output logic                      halted
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  assign imem.addr = pc;
  assign opcode    = inst[31:26];
  assign func      = inst[5:0];

  always_comb begin
    pc4     = pc + PC_STEP;
    br_off  = {{14{inst[15]}}, inst[15:0], 2'b00};
    next_pc = pc4;
    if (Jump && JumpReg)
      next_pc = reg_target;
    else if (Jump)
      next_pc = {pc4[31:28], inst[25:0], 2'b00};
    else if (Branch && branch_cond)
      next_pc = pc4 + br_off;
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      imem.req   <= 1'b0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          // req is registered: coming out of reset it is armed here, after
          // an ack it was already raised on the acknowledging edge.
          if (!imem.req) begin
            imem.req <= 1'b1;
          end else begin
            imem.req <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.rvalid) begin
            inst       <= imem.rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ack) begin
            inst_valid <= 1'b0;
            if (Halted) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              pc       <= next_pc;
              imem.req <= 1'b1;
              state    <= S_REQ;
            end
          end
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: drives the memory side by hand and
// checks addresses, held instruction and next-PC selection.
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_b;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        inst_ack;
  logic        Jump;
  logic        JumpReg;
  logic        Branch;
  logic        Halted;
  logic        branch_cond;
  logic [31:0] reg_target;
  logic        halted;

  int checks   = 0;
  int failures = 0;
  int req_cnt;

  inst_fetch_unit_if imem ();

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .imem        (imem.master),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .opcode      (opcode),
    .func        (func),
    .inst_ack    (inst_ack),
    .Jump        (Jump),
    .JumpReg     (JumpReg),
    .Branch      (Branch),
    .Halted      (Halted),
    .branch_cond (branch_cond),
    .reg_target  (reg_target),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next_req(input string tag, input logic [31:0] exp_addr);
    chk({tag, "_req"}, {31'd0, imem.req}, 32'd1);
    chk({tag, "_addr"}, imem.addr, exp_addr);
  endtask

  // Called in the request cycle; answers after 'delay' cycles.
  task automatic serve(input logic [31:0] word, input int delay, input logic [31:0] exp_pc);
    imem.rvalid = 1'b0;
    tick();
    repeat (delay - 1) tick();
    imem.rvalid = 1'b1;
    imem.rdata  = word;
    tick();
    imem.rvalid = 1'b0;
    chk("serve_valid", {31'd0, inst_valid}, 32'd1);
    chk("serve_inst", inst, word);
    chk("serve_pc", inst_pc, exp_pc);
  endtask

  task automatic ack(input logic j, input logic jr, input logic b, input logic c,
                     input logic h, input logic [31:0] rt);
    Jump = j; JumpReg = jr; Branch = b; branch_cond = c; Halted = h; reg_target = rt;
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0; Jump = 1'b0; JumpReg = 1'b0; Branch = 1'b0;
    branch_cond = 1'b0; Halted = 1'b0; reg_target = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_b = 1'b1; inst_ack = 1'b0; Jump = 1'b0; JumpReg = 1'b0; Branch = 1'b0;
    Halted = 1'b0; branch_cond = 1'b0; reg_target = '0;
    imem.rvalid = 1'b0; imem.rdata = '0;
    tick(); tick();
    rst_b = 1'b0;
    chk("rst_req", {31'd0, imem.req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_addr", imem.addr, 32'd0);

    // basic fetch, one-cycle memory
    tick();
    next_req("t1", 32'h0);
    serve(32'h2008_0005, 1, 32'h0);
    chk("t1_opcode", {26'd0, opcode}, 32'h08);
    chk("t1_func", {26'd0, func}, 32'h05);
    ack(0, 0, 0, 0, 0, 0);
    next_req("t1_next", 32'h4);
    chk("t1_valid_drop", {31'd0, inst_valid}, 32'd0);

    // rvalid in request cycle ignored, then 5-cycle latency; stray acks ignored
    imem.rvalid = 1'b1;
    imem.rdata  = 32'hDEAD_BEEF;
    tick();
    imem.rvalid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      chk("t2_wait_valid", {31'd0, inst_valid}, 32'd0);
      chk("t2_wait_req", {31'd0, imem.req}, 32'd0);
      inst_ack = 1'b1;
      tick();
    end
    inst_ack = 1'b0;
    imem.rvalid = 1'b1;
    imem.rdata  = 32'h0800_0010;
    tick();
    imem.rvalid = 1'b0;
    chk("t2_valid", {31'd0, inst_valid}, 32'd1);
    chk("t2_inst", inst, 32'h0800_0010);
    chk("t2_inst_pc", inst_pc, 32'h4);
    ack(1, 0, 0, 0, 0, 0);
    next_req("t2_jump", 32'h40);

    // branch not taken at 0x40
    serve(32'h1000_FFFE, 1, 32'h40);
    ack(0, 0, 1, 0, 0, 0);
    next_req("br_nt", 32'h44);

    // jump back to 0x40
    serve(32'h0800_0010, 2, 32'h44);
    ack(1, 0, 0, 0, 0, 0);
    next_req("j_back", 32'h40);

    // branch taken, imm=-2 -> 0x44 - 8
    serve(32'h1000_FFFE, 1, 32'h40);
    ack(0, 0, 1, 1, 0, 0);
    next_req("br_t", 32'h3C);

    // JR beats taken branch
    serve(32'h0000_0000, 1, 32'h3C);
    ack(1, 1, 1, 1, 0, 32'h1000_0000);
    next_req("jr_hi", 32'h1000_0000);

    // Jump beats taken branch (branch target would be 0x1000_0404)
    serve(32'h0800_0100, 1, 32'h1000_0000);
    ack(1, 0, 1, 1, 0, 0);
    next_req("j_region", 32'h1000_0400);

    serve(32'h0000_0000, 1, 32'h1000_0400);
    ack(1, 1, 1, 0, 0, 32'h88);
    next_req("jr_88", 32'h88);

    // misaligned target issued unmodified
    serve(32'h0000_0000, 1, 32'h88);
    ack(1, 1, 0, 0, 0, 32'h123);
    next_req("misalign", 32'h123);

    // wrap
    serve(32'h0000_0000, 1, 32'h123);
    ack(1, 1, 0, 0, 0, 32'hFFFF_FFFC);
    next_req("pre_wrap", 32'hFFFF_FFFC);
    serve(32'h0000_0000, 1, 32'hFFFF_FFFC);
    ack(0, 0, 0, 0, 0, 0);
    next_req("wrap", 32'h0);

    // halt
    serve(32'h0000_000C, 1, 32'h0);
    ack(0, 0, 0, 0, 1, 0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, inst_valid}, 32'd0);
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem.req) req_cnt++;
      inst_ack    = i[0];
      imem.rvalid = i[1];
      tick();
    end
    inst_ack = 1'b0;
    imem.rvalid = 1'b0;
    chk("halt_no_req", req_cnt, 32'd0);
    chk("halt_stays", {31'd0, halted}, 32'd1);

    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("halt_rst_flag", {31'd0, halted}, 32'd0);
    chk("halt_rst_req", {31'd0, imem.req}, 32'd0);
    chk("halt_rst_pc", imem.addr, 32'h0);
    tick();
    next_req("after_halt", 32'h0);

    // reset while waiting, with a response arriving on the reset edge
    serve(32'h0000_0000, 1, 32'h0);
    ack(0, 0, 0, 0, 0, 0);
    next_req("pre_wait_rst", 32'h4);
    tick();
    chk("wait_req_low", {31'd0, imem.req}, 32'd0);
    rst_b = 1'b1;
    imem.rvalid = 1'b1;
    imem.rdata  = 32'h1234_5678;
    tick();
    rst_b = 1'b0;
    imem.rvalid = 1'b0;
    chk("wrst_valid", {31'd0, inst_valid}, 32'd0);
    chk("wrst_pc", imem.addr, 32'h0);
    chk("wrst_inst", inst, 32'h0);
    tick();
    next_req("wrst_req", 32'h0);
    serve(32'h2008_0005, 1, 32'h0);
    chk("wrst_opcode", {26'd0, opcode}, 32'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
